// File: rtl/seq_timer_pkg.sv
// Shared state encoding, default parameters and width helper for the serial timer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_timer_pkg;

   // Controller states; all four 2-bit codes are used.
   typedef enum logic [1:0] {
      SEARCH = 2'b00,
      SHIFT  = 2'b01,
      COUNT  = 2'b10,
      DONE   = 2'b11
   } state_t;

   localparam int         DEF_PATTERN_W = 4;
   localparam logic [3:0] DEF_PATTERN   = 4'b1101;
   localparam int         DEF_DELAY_W   = 4;
   localparam int         DEF_TICKS     = 1000;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/seq_timer_if.sv
// Serial timer bus: input bit stream and user ack in, phase flags and remaining delay out.
// Latency: n/a (wires only). Optional abort line exists when SEQ_TIMER_ABORT_EN is defined.
// Backpressure: none; done is held until ack.
interface seq_timer_if
   import seq_timer_pkg::*;
#(
   parameter int DELAY_W = DEF_DELAY_W
);

   logic               data;
   logic               ack;
   logic               shift_ena;
   logic               counting;
   logic               done;
   logic [DELAY_W-1:0] count;

`ifdef SEQ_TIMER_ABORT_EN
   logic               abort;

   modport master (output data, ack, abort, input shift_ena, counting, done, count);
   modport slave  (input data, ack, abort, output shift_ena, counting, done, count);
`else
   modport master (output data, ack, input shift_ena, counting, done, count);
   modport slave  (input data, ack, output shift_ena, counting, done, count);
`endif

endinterface

// File: rtl/seq_pattern_det.sv
// Overlapping serial start-pattern detector; first received bit lands in the pattern MSB.
// Latency: match is combinational on the current bit against the registered history.
// Backpressure: none; en gates capture, clr or reset empty the history on the next edge.
module seq_pattern_det
   import seq_timer_pkg::*;
#(
   parameter int                   PATTERN_W = DEF_PATTERN_W,
   parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic data,
   output logic match
);

   // Only the newest PATTERN_W-1 bits are kept; the current bit completes the window.
   logic [PATTERN_W-2:0] hist_q;
   logic [PATTERN_W-2:0] hist_d;
   logic [PATTERN_W-1:0] window;

   assign window = {hist_q, data};
   assign match  = en && (window == PATTERN);

   // History next-state: clearing wins over shifting so stale bits never survive re-entry.
   always_comb begin
      hist_d = hist_q;
      if (clr) begin
         hist_d = '0;
      end else if (en) begin
         hist_d = window[PATTERN_W-2:0];
      end
   end

   // History register.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

endmodule

// File: rtl/seq_timer_ctrl.sv
// Serial timer controller: find start pattern, shift in DELAY_W-bit delay, count (delay+1)*TICKS, raise done.
// Latency: shift_ena the cycle after the last pattern bit; done (delay+1)*TICKS cycles after counting starts.
// Backpressure: done held until ack; optional abort in SHIFT/COUNT when SEQ_TIMER_ABORT_EN is defined.
module seq_timer_ctrl
   import seq_timer_pkg::*;
#(
   parameter int                   PATTERN_W = DEF_PATTERN_W,
   parameter logic [PATTERN_W-1:0] PATTERN   = DEF_PATTERN,
   parameter int                   DELAY_W   = DEF_DELAY_W,
   parameter int                   TICKS     = DEF_TICKS
) (
   input logic        clk,
   input logic        reset,
   seq_timer_if.slave bus
);

   localparam int                TICK_W    = cnt_width(TICKS);
   localparam int                BIT_W     = cnt_width(DELAY_W);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_W - 1);

   state_t               state_q;
   state_t               state_d;
   logic [DELAY_W-1:0]   delay_q;
   logic [DELAY_W-1:0]   delay_d;
   logic [BIT_W-1:0]     bit_q;
   logic [BIT_W-1:0]     bit_d;
   logic [TICK_W-1:0]    tick_q;
   logic [TICK_W-1:0]    tick_d;

   logic                 det_en;
   logic                 det_clr;
   logic                 det_match;
   logic                 abort_req;

`ifdef SEQ_TIMER_ABORT_EN
   assign abort_req = bus.abort;
`else
   assign abort_req = 1'b0;
`endif

   // History only advances while searching, and is emptied on the edge that returns to SEARCH.
   assign det_en  = (state_q == SEARCH);
   assign det_clr = (state_d == SEARCH) && (state_q != SEARCH);

   seq_pattern_det #(
      .PATTERN_W (PATTERN_W),
      .PATTERN   (PATTERN)
   ) u_det (
      .clk   (clk),
      .reset (reset),
      .clr   (det_clr),
      .en    (det_en),
      .data  (bus.data),
      .match (det_match)
   );

   // Next-state, delay shift/decrement, bit and tick counter updates.
   always_comb begin
      state_d = state_q;
      delay_d = delay_q;
      bit_d   = bit_q;
      tick_d  = tick_q;
      case (state_q)
         SEARCH: begin
            if (det_match) begin
               state_d = SHIFT;
               bit_d   = '0;
            end
         end
         SHIFT: begin
            if (abort_req) begin
               state_d = SEARCH;
            end else begin
               delay_d = {delay_q[DELAY_W-2:0], bus.data};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  state_d = COUNT;
                  tick_d  = TICK_LAST;
               end
            end
         end
         COUNT: begin
            if (abort_req) begin
               state_d = SEARCH;
            end else if (tick_q == '0) begin
               // End of one delay unit: either start the next unit or finish.
               if (delay_q != '0) begin
                  delay_d = delay_q - 1'b1;
                  tick_d  = TICK_LAST;
               end else begin
                  state_d = DONE;
               end
            end else begin
               tick_d = tick_q - 1'b1;
            end
         end
         DONE: begin
            if (bus.ack) begin
               state_d = SEARCH;
            end
         end
         default: begin
            state_d = SEARCH;
         end
      endcase
   end

   // Control and datapath registers; reset overrides any in-flight shift or count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEARCH;
         delay_q <= '0;
         bit_q   <= '0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         delay_q <= delay_d;
         bit_q   <= bit_d;
         tick_q  <= tick_d;
      end
   end

   // Moore decodes of state; count exposes the remaining delay units.
   assign bus.shift_ena = (state_q == SHIFT);
   assign bus.counting  = (state_q == COUNT);
   assign bus.done      = (state_q == DONE);
   assign bus.count     = delay_q;

endmodule

// File: tb/tb_seq_timer_ctrl.sv
// Bench for seq_timer_ctrl with TICKS=4: per-cycle stimulus plan, expected outputs queued as each cycle is driven.
// Latency: outputs compared on the negedge after the posedge that consumed the stimulus.
// Backpressure: n/a; abort scenario built only when SEQ_TIMER_ABORT_EN is defined.
module tb_seq_timer_ctrl;

   localparam int T  = 4;
   localparam int DW = 4;

   typedef struct packed {
      logic       r;
      logic       d;
      logic       a;
      logic       ab;
      logic [6:0] e;
   } plan_t;

   logic       clk = 1'b0;
   logic       reset;
   int         n_checks = 0;
   int         n_fail   = 0;
   plan_t      plan_q[$];
   logic [6:0] exp_q[$];

   seq_timer_if #(.DELAY_W(DW)) bus();

   seq_timer_ctrl #(
      .PATTERN_W (4),
      .PATTERN   (4'b1101),
      .DELAY_W   (DW),
      .TICKS     (T)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected {shift_ena, counting, done, count}.
   function automatic logic [6:0] ob(input logic se, input logic ct, input logic dn, input logic [3:0] cnt);
      return {se, ct, dn, cnt};
   endfunction

   function automatic void add_cyc(input logic r, input logic d, input logic a, input logic ab, input logic [6:0] e);
      plan_t p;
      p.r  = r;
      p.d  = d;
      p.a  = a;
      p.ab = ab;
      p.e  = e;
      plan_q.push_back(p);
   endfunction

   function automatic void add_reset(input int n);
      for (int i = 0; i < n; i++) add_cyc(1'b1, 1'b1, rb(), rb(), ob(1'b0, 1'b0, 1'b0, 4'd0));
   endfunction

   // 1,1,0,1 from an empty history; shift_ena follows the last bit.
   function automatic void add_pattern(input logic [3:0] prev);
      logic [3:0] pat;
      pat = 4'b1101;
      for (int i = 3; i >= 0; i--)
         add_cyc(1'b0, pat[i], rb(), rb(), (i == 0) ? ob(1'b1, 1'b0, 1'b0, prev) : ob(1'b0, 1'b0, 1'b0, prev));
   endfunction

   // Delay bits MSB-first; count shows the shift register filling from its previous contents.
   function automatic void add_delay(input logic [3:0] prev, input logic [3:0] dly);
      int v;
      for (int i = 0; i < DW; i++) begin
         v = ((int'(prev) << (i + 1)) | (int'(dly) >> (DW - 1 - i))) & 15;
         add_cyc(1'b0, dly[DW-1-i], rb(), 1'b0,
                 (i == DW - 1) ? ob(1'b0, 1'b1, 1'b0, 4'(v)) : ob(1'b1, 1'b0, 1'b0, 4'(v)));
      end
   endfunction

   // Cycles after counting starts; the ((dly+1)*T)-th one lands in DONE.
   function automatic void add_count(input int dly, input int n);
      for (int c = 1; c <= n; c++) begin
         if (c < (dly + 1) * T) add_cyc(1'b0, rb(), rb(), 1'b0, ob(1'b0, 1'b1, 1'b0, 4'(dly - c / T)));
         else add_cyc(1'b0, rb(), 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b1, 4'd0));
      end
   endfunction

   function automatic void add_done(input int n);
      for (int i = 0; i < n; i++) add_cyc(1'b0, rb(), 1'b0, rb(), ob(1'b0, 1'b0, 1'b1, 4'd0));
   endfunction

   function automatic void add_ack();
      add_cyc(1'b0, rb(), 1'b1, rb(), ob(1'b0, 1'b0, 1'b0, 4'd0));
   endfunction

   task automatic test_reset();
      plan_t p; logic [6:0] e, o; int step = 0;
      add_reset(2);
      for (int i = 0; i < 2; i++) add_cyc(1'b0, 1'b0, 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b0, 4'd0));
      while (plan_q.size() > 0 || exp_q.size() > 0) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {bus.shift_ena, bus.counting, bus.done, bus.count};
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset step %0d: se/ct/dn/cnt got %b required %b", step, o, e); end
         end
         if (plan_q.size() > 0) begin
            p = plan_q.pop_front(); reset = p.r; bus.data = p.d; bus.ack = p.a;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = p.ab;
`endif
            exp_q.push_back(p.e);
         end else begin
            reset = 1'b0; bus.data = 1'b0; bus.ack = 1'b0;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = 1'b0;
`endif
         end
         step++;
      end
   endtask

   task automatic test_basic();
      plan_t p; logic [6:0] e, o; int step = 0;
      add_reset(1);
      add_pattern(4'd0);
      add_delay(4'd0, 4'b0010);
      add_count(2, 12);
      add_done(5);
      add_ack();
      while (plan_q.size() > 0 || exp_q.size() > 0) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {bus.shift_ena, bus.counting, bus.done, bus.count};
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL basic step %0d: se/ct/dn/cnt got %b required %b", step, o, e); end
         end
         if (plan_q.size() > 0) begin
            p = plan_q.pop_front(); reset = p.r; bus.data = p.d; bus.ack = p.a;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = p.ab;
`endif
            exp_q.push_back(p.e);
         end else begin
            reset = 1'b0; bus.data = 1'b0; bus.ack = 1'b0;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = 1'b0;
`endif
         end
         step++;
      end
   endtask

   task automatic test_overlap();
      plan_t p; logic [6:0] e, o; int step = 0;
      logic [4:0] bits;
      bits = 5'b11101;
      add_reset(1);
      for (int i = 4; i >= 0; i--)
         add_cyc(1'b0, bits[i], rb(), rb(), (i == 0) ? ob(1'b1, 1'b0, 1'b0, 4'd0) : ob(1'b0, 1'b0, 1'b0, 4'd0));
      add_delay(4'd0, 4'b0001);
      add_count(1, 8);
      add_done(1);
      add_ack();
      while (plan_q.size() > 0 || exp_q.size() > 0) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {bus.shift_ena, bus.counting, bus.done, bus.count};
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL overlap step %0d: se/ct/dn/cnt got %b required %b", step, o, e); end
         end
         if (plan_q.size() > 0) begin
            p = plan_q.pop_front(); reset = p.r; bus.data = p.d; bus.ack = p.a;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = p.ab;
`endif
            exp_q.push_back(p.e);
         end else begin
            reset = 1'b0; bus.data = 1'b0; bus.ack = 1'b0;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = 1'b0;
`endif
         end
         step++;
      end
   endtask

   task automatic test_zero_delay();
      plan_t p; logic [6:0] e, o; int step = 0;
      add_reset(1);
      add_pattern(4'd0);
      add_delay(4'd0, 4'b0000);
      add_count(0, 4);
      add_done(2);
      add_ack();
      while (plan_q.size() > 0 || exp_q.size() > 0) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {bus.shift_ena, bus.counting, bus.done, bus.count};
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL zero_delay step %0d: se/ct/dn/cnt got %b required %b", step, o, e); end
         end
         if (plan_q.size() > 0) begin
            p = plan_q.pop_front(); reset = p.r; bus.data = p.d; bus.ack = p.a;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = p.ab;
`endif
            exp_q.push_back(p.e);
         end else begin
            reset = 1'b0; bus.data = 1'b0; bus.ack = 1'b0;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = 1'b0;
`endif
         end
         step++;
      end
   endtask

   // Done held 10 cycles; 1,1,0 then 1-with-ack fed in DONE must not start a shift.
   task automatic test_done_ack();
      plan_t p; logic [6:0] e, o; int step = 0;
      add_reset(1);
      add_pattern(4'd0);
      add_delay(4'd0, 4'b0001);
      add_count(1, 8);
      add_done(6);
      add_cyc(1'b0, 1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b1, 4'd0));
      add_cyc(1'b0, 1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b1, 4'd0));
      add_cyc(1'b0, 1'b0, 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b1, 4'd0));
      add_cyc(1'b0, 1'b1, 1'b1, 1'b0, ob(1'b0, 1'b0, 1'b0, 4'd0));
      add_cyc(1'b0, 1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b0, 4'd0));
      add_cyc(1'b0, 1'b0, 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b0, 4'd0));
      add_cyc(1'b0, 1'b0, 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b0, 4'd0));
      add_pattern(4'd0);
      add_delay(4'd0, 4'b0000);
      add_count(0, 4);
      add_done(1);
      add_ack();
      while (plan_q.size() > 0 || exp_q.size() > 0) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {bus.shift_ena, bus.counting, bus.done, bus.count};
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL done_ack step %0d: se/ct/dn/cnt got %b required %b", step, o, e); end
         end
         if (plan_q.size() > 0) begin
            p = plan_q.pop_front(); reset = p.r; bus.data = p.d; bus.ack = p.a;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = p.ab;
`endif
            exp_q.push_back(p.e);
         end else begin
            reset = 1'b0; bus.data = 1'b0; bus.ack = 1'b0;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = 1'b0;
`endif
         end
         step++;
      end
   endtask

`ifdef SEQ_TIMER_ABORT_EN
   // Abort on the 3rd COUNT cycle keeps delay, never reaches DONE; a fresh pattern restarts.
   task automatic test_abort();
      plan_t p; logic [6:0] e, o; int step = 0;
      add_reset(1);
      add_pattern(4'd0);
      add_delay(4'd0, 4'b0010);
      add_count(2, 2);
      add_cyc(1'b0, rb(), rb(), 1'b1, ob(1'b0, 1'b0, 1'b0, 4'd2));
      for (int i = 0; i < 4; i++) add_cyc(1'b0, 1'b0, rb(), rb(), ob(1'b0, 1'b0, 1'b0, 4'd2));
      add_pattern(4'd2);
      add_delay(4'd2, 4'b0001);
      add_count(1, 8);
      add_done(2);
      add_ack();
      while (plan_q.size() > 0 || exp_q.size() > 0) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {bus.shift_ena, bus.counting, bus.done, bus.count};
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL abort step %0d: se/ct/dn/cnt got %b required %b", step, o, e); end
         end
         if (plan_q.size() > 0) begin
            p = plan_q.pop_front(); reset = p.r; bus.data = p.d; bus.ack = p.a; bus.abort = p.ab;
            exp_q.push_back(p.e);
         end else begin
            reset = 1'b0; bus.data = 1'b0; bus.ack = 1'b0; bus.abort = 1'b0;
         end
         step++;
      end
   endtask
`endif

   // Reset held 2 cycles mid-COUNT, then a pattern proves the FSM is back in SEARCH.
   task automatic test_reset_midcount();
      plan_t p; logic [6:0] e, o; int step = 0;
      add_reset(1);
      add_pattern(4'd0);
      add_delay(4'd0, 4'b0011);
      add_count(3, 5);
      add_reset(2);
      for (int i = 0; i < 2; i++) add_cyc(1'b0, 1'b0, 1'b0, 1'b0, ob(1'b0, 1'b0, 1'b0, 4'd0));
      add_pattern(4'd0);
      add_reset(1);
      while (plan_q.size() > 0 || exp_q.size() > 0) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = {bus.shift_ena, bus.counting, bus.done, bus.count};
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_midcount step %0d: se/ct/dn/cnt got %b required %b", step, o, e); end
         end
         if (plan_q.size() > 0) begin
            p = plan_q.pop_front(); reset = p.r; bus.data = p.d; bus.ack = p.a;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = p.ab;
`endif
            exp_q.push_back(p.e);
         end else begin
            reset = 1'b0; bus.data = 1'b0; bus.ack = 1'b0;
`ifdef SEQ_TIMER_ABORT_EN
            bus.abort = 1'b0;
`endif
         end
         step++;
      end
   endtask

   initial begin
      reset    = 1'b1;
      bus.data = 1'b0;
      bus.ack  = 1'b0;
`ifdef SEQ_TIMER_ABORT_EN
      bus.abort = 1'b0;
`endif
      test_reset();
      test_basic();
      test_overlap();
      test_zero_delay();
      test_done_ack();
`ifdef SEQ_TIMER_ABORT_EN
      test_abort();
`endif
      test_reset_midcount();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
